// File: rtl/spectrum_peak_tracker_pkg.sv
// Shared constants, FSM encoding and float helpers for the spectrum peak tracker.
// Non-negative IEEE-754 singles order like unsigned {exp,mant}, so compares are integer compares.
package spectrum_peak_tracker_pkg;

    localparam int         SPT_SIZE        = 64;
    localparam int         SPT_ABITS       = $clog2(SPT_SIZE);
    localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } spt_state_t;

    // Negative values, NaN and Inf are unusable magnitudes.
    function automatic logic is_bad(input logic [31:0] f);
        return f[31] || (f[30:23] == FP_EXP_ALL_ONES);
    endfunction

    // Bad words compare as 0.0.
    function automatic logic [30:0] sanitise(input logic [31:0] f);
        return is_bad(f) ? 31'd0 : f[30:0];
    endfunction

endpackage

// File: rtl/spectrum_peak_tracker_pingpong_ram.sv
// Two SIZE x 32 banks behind one write port and one registered read port.
// The bank select bits form the top address bit so the pair maps onto one block RAM.
module spt_pingpong_ram #(
    parameter int SIZE  = 64,
    parameter int ABITS = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [ABITS-1:0] rd_addr,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [2*SIZE];

    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/spectrum_peak_tracker.sv
// Per-frame peak/threshold tracker for a stream of float32 bin magnitudes.
// Frames land in a ping-pong buffer; the last committed frame stays readable.
module spectrum_peak_tracker
    import spectrum_peak_tracker_pkg::*;
#(
    parameter int SIZE    = SPT_SIZE,
    parameter bit SKIP_DC = 1'b1,
    localparam int ABITS  = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mag_in,
    input  logic             mag_valid,
    input  logic [31:0]      thresh,
    input  logic             rd_lock,
    input  logic [ABITS-1:0] rd_addr,
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    output logic [ABITS-1:0] peak_bin,
    output logic [31:0]      peak_mag,
    output logic [ABITS:0]   over_cnt,
    output logic             frame_done,
    output logic             frame_drop,
    output logic             bad_sample
);

    spt_state_t       state;
    logic [ABITS-1:0] bin_cnt;
    logic             wr_bank;
    logic [30:0]      thr_q;
    logic [30:0]      run_max;
    logic [ABITS-1:0] run_bin;
    logic [ABITS:0]   run_over;

    logic        first, last, swap, wr_sel, rd_sel, in_search;
    logic [30:0] s, thr_cur;

    // A word arriving in COMMIT already belongs to the next frame, so the
    // write bank and read bank both switch during that cycle.
    always_comb begin
        first     = (bin_cnt == '0);
        last      = (state == ACCUM) && (&bin_cnt);
        swap      = (state == COMMIT) && !rd_lock;
        wr_sel    = wr_bank ^ swap;
        rd_sel    = ~wr_sel;
        s         = sanitise(mag_in);
        thr_cur   = sanitise(thresh);
        in_search = !(SKIP_DC && first);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            wr_bank    <= 1'b0;
            thr_q      <= '0;
            run_max    <= '0;
            run_bin    <= '0;
            run_over   <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            over_cnt   <= '0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            bad_sample <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (mag_valid && is_bad(mag_in))
                bad_sample <= 1'b1;

            if (state == COMMIT) begin
                if (rd_lock) begin
                    frame_drop <= 1'b1;
                end else begin
                    wr_bank    <= ~wr_bank;
                    peak_bin   <= run_bin;
                    peak_mag   <= {1'b0, run_max};
                    over_cnt   <= run_over;
                    frame_done <= 1'b1;
                end
            end

            if (mag_valid) begin
                if (first) begin
                    // With DC skipped, an all-zero frame must report bin 1.
                    thr_q    <= thr_cur;
                    run_max  <= in_search ? s : 31'd0;
                    run_bin  <= SKIP_DC ? ABITS'(1) : '0;
                    run_over <= (in_search && (s > thr_cur)) ? (ABITS+1)'(1) : '0;
                end else begin
                    if (s > run_max) begin
                        run_max <= s;
                        run_bin <= bin_cnt;
                    end
                    if (s > thr_q)
                        run_over <= run_over + 1'b1;
                end
                bin_cnt <= bin_cnt + 1'b1;
                state   <= last ? COMMIT : ACCUM;
            end else if (state == COMMIT) begin
                state <= IDLE;
            end
        end
    end

    spt_pingpong_ram #(
        .SIZE  (SIZE),
        .ABITS (ABITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (mag_valid),
        .wr_bank (wr_sel),
        .wr_addr (bin_cnt),
        .wr_data (mag_in),
        .rd_en   (rd_en),
        .rd_bank (rd_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Directed bench for spectrum_peak_tracker: frame expectations are queued as frames are
// streamed and checked against each frame_done pulse; reads and flags are checked inline.
module tb_spectrum_peak_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mag_in;
    logic        mag_valid;
    logic [31:0] thresh;
    logic        rd_lock;
    logic [5:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [5:0]  peak_bin;
    logic [31:0] peak_mag;
    logic [6:0]  over_cnt;
    logic        frame_done;
    logic        frame_drop;
    logic        bad_sample;

    always #5 clk = ~clk;

    spectrum_peak_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .mag_in     (mag_in),
        .mag_valid  (mag_valid),
        .thresh     (thresh),
        .rd_lock    (rd_lock),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .over_cnt   (over_cnt),
        .frame_done (frame_done),
        .frame_drop (frame_drop),
        .bad_sample (bad_sample)
    );

    typedef struct {
        logic [5:0]  bin;
        logic [31:0] mag;
        logic [6:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fr [64];
    int          vecs = 0;
    int          errs = 0;
    int          done_cnt = 0;

    // Exact float32 for small positive integers.
    function automatic logic [31:0] to_f(input int v);
        int p;
        if (v == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 31; b++)
            if (((v >> b) & 1) == 1) p = b;
        return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h7FFFFF)};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)};
    endfunction

    function automatic logic [30:0] san(input logic [31:0] f);
        if (f[31] || f[30:23] == 8'hFF) return 31'd0;
        return f[30:0];
    endfunction

    // Reference result for the frame currently in fr[], DC bin excluded.
    function automatic exp_t model(input logic [31:0] thr_w);
        exp_t        e;
        logic [30:0] m, t, v;
        m = '0; t = san(thr_w);
        e.bin = 6'd1; e.cnt = '0;
        for (int i = 1; i < 64; i++) begin
            v = san(fr[i]);
            if (v > m) begin m = v; e.bin = 6'(i); end
            if (v > t) e.cnt = e.cnt + 7'd1;
        end
        e.mag = {1'b0, m};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        mag_in    = w;
        mag_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mag_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] thr_w, input bit gaps, input bit expect_done);
        if (expect_done) exp_q.push_back(model(thr_w));
        thresh = thr_w;
        for (int i = 0; i < 64; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            drive(fr[i]);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic rd_check(input logic [5:0] a, input logic [31:0] expv, input string tag);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        chk(tag, rd_data, expv);
    endtask

    initial begin
        rst = 1'b1; mag_in = '0; mag_valid = 1'b0; thresh = '0;
        rd_lock = 1'b0; rd_addr = '0; rd_en = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (frame_done === 1'b1) begin
                        done_cnt++;
                        vecs++;
                        assert (exp_q.size() != 0) else begin
                            errs++;
                            $error("FAIL unexpected_done: observed frame_done=1 expected 0");
                        end
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("sb_peak_bin", 32'(peak_bin), 32'(e.bin));
                            chk("sb_peak_mag", peak_mag, e.mag);
                            chk("sb_over_cnt", 32'(over_cnt), 32'(e.cnt));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_peak_bin", 32'(peak_bin), 32'd0);
        chk("rst_peak_mag", peak_mag, 32'd0);
        chk("rst_over_cnt", 32'(over_cnt), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_bad", 32'(bad_sample), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;

        // Ramp
        for (int i = 0; i < 64; i++) fr[i] = to_f(i);
        send_frame(32'h41FC0000, 1'b0, 1'b1);
        idle(1);
        wait_done(1, "ramp_done");
        chk("ramp_bin", 32'(peak_bin), 32'd63);
        chk("ramp_mag", peak_mag, 32'h427C0000);
        chk("ramp_over", 32'(over_cnt), 32'd32);

        // Tie and DC exclusion
        for (int i = 0; i < 64; i++) fr[i] = 32'h0;
        fr[0] = 32'h42C80000; fr[5] = 32'h40E00000; fr[9] = 32'h40E00000;
        send_frame(32'h0, 1'b0, 1'b1);
        idle(1);
        wait_done(2, "tie_done");
        chk("tie_bin", 32'(peak_bin), 32'd5);
        chk("tie_mag", peak_mag, 32'h40E00000);
        chk("tie_over", 32'(over_cnt), 32'd2);

        // Ping-pong: frame A readable while frame B streams
        for (int i = 0; i < 64; i++) fr[i] = 32'h3F800000;
        send_frame(32'h0, 1'b0, 1'b1);
        idle(1);
        wait_done(3, "ppA_done");
        for (int i = 0; i < 64; i++) fr[i] = 32'h40000000;
        exp_q.push_back(model(32'h0));
        thresh = 32'h0;
        for (int i = 0; i < 64; i++) begin
            drive(fr[i]);
            if (i == 20) begin rd_en = 1'b1; rd_addr = 6'd10; end
            if (i == 21) begin rd_en = 1'b0; chk("pp_read_old", rd_data, 32'h3F800000); end
            if (i == 40) chk("pp_read_hold", rd_data, 32'h3F800000);
        end
        idle(1);
        wait_done(4, "ppB_done");
        rd_check(6'd10, 32'h40000000, "pp_read_new");

        // Lock: frame C discarded, B stays visible
        rd_lock = 1'b1;
        for (int i = 0; i < 64; i++) fr[i] = 32'h40400000;
        send_frame(32'h0, 1'b0, 1'b0);
        idle(4);
        chk("lock_drop", 32'(frame_drop), 32'd1);
        chk("lock_no_done", 32'(done_cnt), 32'd4);
        chk("lock_peak_hold", peak_mag, 32'h40000000);
        rd_check(6'd10, 32'h40000000, "lock_read");
        rd_lock = 1'b0;
        for (int i = 0; i < 64; i++) fr[i] = to_f(64 - i);
        send_frame(to_f(10), 1'b0, 1'b1);
        idle(1);
        wait_done(5, "unlock_done");
        chk("unlock_bin", 32'(peak_bin), 32'd1);
        chk("unlock_over", 32'(over_cnt), 32'd53);
        rd_check(6'd10, to_f(54), "unlock_read");
        chk("drop_sticky", 32'(frame_drop), 32'd1);

        // Random gaps, then two frames back to back
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) fr[i] = rnd_f();
            send_frame(rnd_f(), 1'b1, 1'b1);
        end
        idle(1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) fr[i] = rnd_f();
            send_frame(rnd_f(), 1'b0, 1'b1);
        end
        idle(1);
        wait_done(10, "stream_done");

        // NaN sample, then reset mid-frame
        chk("bad_pre", 32'(bad_sample), 32'd0);
        for (int i = 0; i < 64; i++) fr[i] = 32'h0;
        fr[2] = 32'h40A00000; fr[7] = 32'h7FC00000;
        send_frame(32'h0, 1'b0, 1'b1);
        idle(1);
        wait_done(11, "nan_done");
        chk("nan_bad", 32'(bad_sample), 32'd1);
        chk("nan_bin", 32'(peak_bin), 32'd2);
        chk("nan_over", 32'(over_cnt), 32'd1);
        thresh = 32'h0;
        for (int i = 0; i <= 30; i++) drive(to_f(i + 1));
        #2 rst = 1'b1;
        #1;
        chk("arst_peak_bin", 32'(peak_bin), 32'd0);
        chk("arst_peak_mag", peak_mag, 32'd0);
        chk("arst_over_cnt", 32'(over_cnt), 32'd0);
        chk("arst_drop", 32'(frame_drop), 32'd0);
        chk("arst_bad", 32'(bad_sample), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        mag_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) fr[i] = to_f(i);
        send_frame(32'h42200000, 1'b0, 1'b1);
        idle(1);
        wait_done(12, "clean_done");
        chk("clean_bin", 32'(peak_bin), 32'd63);
        chk("clean_over", 32'(over_cnt), 32'd23);
        rd_check(6'd63, to_f(63), "clean_read");

        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
